// File: rtl/fft_pkg.sv
// Shared types and address math for the in-place radix-2 DIT FFT stage sequencer.
package fft_pkg;

  localparam int unsigned LOG2N_MAX = 12;
  localparam int unsigned STAGE_W   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [LOG2N_MAX-1:0] adr_a;
    logic [LOG2N_MAX-1:0] adr_b;
    logic [LOG2N_MAX-1:0] tw;
  } bf_t;

  // Operand pair and twiddle index of butterfly k in stage s of a 2^log2n transform.
  function automatic bf_t bf_addr(input logic [STAGE_W-1:0]   log2n,
                                  input logic [STAGE_W-1:0]   s,
                                  input logic [LOG2N_MAX-1:0] k);
    bf_t                  r;
    logic [LOG2N_MAX-1:0] span;
    logic [LOG2N_MAX-1:0] pos;
    logic [LOG2N_MAX-1:0] grp;
    span    = LOG2N_MAX'(1) << s;
    pos     = k & (span - LOG2N_MAX'(1));
    grp     = k >> s;
    r.adr_a = (grp << (s + STAGE_W'(1))) | pos;
    r.adr_b = r.adr_a + span;
    r.tw    = pos << (log2n - STAGE_W'(1) - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Clock-enabled shift register with synchronous clear; realigns read info as write-back info.
module fft_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < int'(DEPTH); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= '0;
      end
    end else if (ce) begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Issues one butterfly per enabled cycle for each FFT stage, drains between stages,
// and replays read addresses as write-back addresses after the butterfly latency.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = 10,
  parameter int unsigned BF_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_adr_a,
  output logic [LOG2N-1:0] rd_adr_b,
  output logic [LOG2N-2:0] tw_adr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_adr_a,
  output logic [LOG2N-1:0] wr_adr_b
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned DW = 1 + 2 * LOG2N;

  state_e               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [KW-1:0]        k_q, k_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [LOG2N-1:0]     rd_adr_a_q, rd_adr_a_d;
  logic [LOG2N-1:0]     rd_adr_b_q, rd_adr_b_d;
  logic [LOG2N-2:0]     tw_adr_q, tw_adr_d;

  logic                 issue;
  logic [STAGE_W-1:0]   iss_stage;
  logic [KW-1:0]        iss_k;
  bf_t                  bf_c;
  logic                 unused_bf;
  logic [DW-1:0]        wb_c;

  // Next state plus the butterfly (if any) presented on the read port next cycle.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    iss_stage = stage_q;
    iss_k     = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          stage_d   = '0;
          k_d       = '0;
          issue     = 1'b1;
          iss_stage = '0;
        end
      end
      ISSUE: begin
        if (&k_q) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          k_d   = k_q + KW'(1);
          issue = 1'b1;
          iss_k = k_d;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'(BF_LAT - 1)) begin
          if (stage_q == STAGE_W'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d   = ISSUE;
            stage_d   = stage_q + STAGE_W'(1);
            k_d       = '0;
            issue     = 1'b1;
            iss_stage = stage_d;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase

    bf_c       = bf_addr(STAGE_W'(LOG2N), iss_stage, LOG2N_MAX'(iss_k));
    rd_en_d    = issue;
    rd_adr_a_d = issue ? LOG2N'(bf_c.adr_a) : '0;
    rd_adr_b_d = issue ? LOG2N'(bf_c.adr_b) : '0;
    tw_adr_d   = issue ? (LOG2N-1)'(bf_c.tw) : '0;
    busy_d     = (state_d == ISSUE) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // High address bits of the shared helper are zero for legal LOG2N.
  assign unused_bf = ^bf_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_adr_a_q <= '0;
      rd_adr_b_q <= '0;
      tw_adr_q   <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_adr_a_q <= rd_adr_a_d;
      rd_adr_b_q <= rd_adr_b_d;
      tw_adr_q   <= tw_adr_d;
    end
  end

  fft_delay_line #(
    .WIDTH(DW),
    .DEPTH(BF_LAT)
  ) u_wb_delay (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .din ({rd_en_q, rd_adr_a_q, rd_adr_b_q}),
    .dout(wb_c)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign stage    = stage_q;
  assign rd_en    = rd_en_q;
  assign rd_adr_a = rd_adr_a_q;
  assign rd_adr_b = rd_adr_b_q;
  assign tw_adr   = tw_adr_q;
  assign wr_en    = wb_c[DW-1];
  assign wr_adr_a = wb_c[2*LOG2N-1:LOG2N];
  assign wr_adr_b = wb_c[LOG2N-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: schedule model checked every cycle on two configurations,
// plus hand-computed expectations for the small transform.
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  localparam int TD3  = 1 + 3 * ((1 << 2) + 2);
  localparam int TD10 = 1 + 10 * ((1 << 9) + 4);

  // Small configuration: LOG2N=3, BF_LAT=2
  logic       rst3 = 1'b1, ce3 = 1'b1, start3 = 1'b0;
  logic       busy3, done3, rd_en3, wr_en3;
  logic [3:0] stage3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [1:0] tw3;

  // Large configuration: LOG2N=10, BF_LAT=4
  logic       rst10 = 1'b1, ce10 = 1'b1, start10 = 1'b0;
  logic       busy10, done10, rd_en10, wr_en10;
  logic [3:0] stage10;
  logic [9:0] ra10, rb10, wa10, wb10;
  logic [8:0] tw10;

  fft_stage_sequencer #(.LOG2N(3), .BF_LAT(2)) dut3 (
    .clk(clk), .rst(rst3), .ce(ce3), .start(start3), .busy(busy3), .done(done3),
    .stage(stage3), .rd_en(rd_en3), .rd_adr_a(ra3), .rd_adr_b(rb3), .tw_adr(tw3),
    .wr_en(wr_en3), .wr_adr_a(wa3), .wr_adr_b(wb3));

  fft_stage_sequencer #(.LOG2N(10), .BF_LAT(4)) dut10 (
    .clk(clk), .rst(rst10), .ce(ce10), .start(start10), .busy(busy10), .done(done10),
    .stage(stage10), .rd_en(rd_en10), .rd_adr_a(ra10), .rd_adr_b(rb10), .tw_adr(tw10),
    .wr_en(wr_en10), .wr_adr_a(wa10), .wr_adr_b(wb10));

  typedef struct {
    bit busy, done, rd, wr;
    int stage, ra, rb, tw, wa, wb;
  } exp_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Butterfly k of stage s: blocks of 2*span, partner span away, twiddle stride N/(2*span).
  function automatic void pair(input int lg, input int s, input int k,
                               output int a, output int b, output int tw);
    int span;
    span = 1 << s;
    a  = (k / span) * 2 * span + (k % span);
    b  = a + span;
    tw = (k % span) * (1 << (lg - 1 - s));
  endfunction

  // Expected outputs t enabled cycles after an accepted start.
  function automatic exp_t model(input int lg, input int lat, input bit act, input int t);
    exp_t e;
    int half, per, tdone, u, s, r, dummy;
    e = '{default: 0};
    half  = 1 << (lg - 1);
    per   = half + lat;
    tdone = 1 + lg * per;
    if (!act) return e;
    e.busy = (t < tdone);
    e.done = (t == tdone);
    if (e.busy) begin
      s = (t - 1) / per;
      r = (t - 1) % per;
      e.stage = s;
      if (r < half) begin
        e.rd = 1'b1;
        pair(lg, s, r, e.ra, e.rb, e.tw);
      end
    end
    u = t - lat;
    if (u >= 1 && u < tdone) begin
      s = (u - 1) / per;
      r = (u - 1) % per;
      if (r < half) begin
        e.wr = 1'b1;
        pair(lg, s, r, e.wa, e.wb, dummy);
      end
    end
    return e;
  endfunction

  bit act3 = 1'b0, act10 = 1'b0;
  int t3 = 0, t10 = 0;

  always @(posedge clk) begin
    if (rst3) begin
      act3 <= 1'b0; t3 <= 0;
    end else if (ce3) begin
      if (act3) begin
        if (t3 >= TD3) begin act3 <= 1'b0; t3 <= 0; end
        else t3 <= t3 + 1;
      end else if (start3) begin
        act3 <= 1'b1; t3 <= 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst10) begin
      act10 <= 1'b0; t10 <= 0;
    end else if (ce10) begin
      if (act10) begin
        if (t10 >= TD10) begin act10 <= 1'b0; t10 <= 0; end
        else t10 <= t10 + 1;
      end else if (start10) begin
        act10 <= 1'b1; t10 <= 1;
      end
    end
  end

  task automatic cmp(input string tag, input exp_t e, input bit busy, input bit done,
                     input int stage, input bit rd, input int ra, input int rb, input int tw,
                     input bit wr, input int wa, input int wb);
    chk({tag, " busy"}, int'(busy), int'(e.busy));
    chk({tag, " done"}, int'(done), int'(e.done));
    if (e.busy) chk({tag, " stage"}, stage, e.stage);
    chk({tag, " rd_en"}, int'(rd), int'(e.rd));
    chk({tag, " rd_adr_a"}, ra, e.ra);
    chk({tag, " rd_adr_b"}, rb, e.rb);
    chk({tag, " tw_adr"}, tw, e.tw);
    chk({tag, " wr_en"}, int'(wr), int'(e.wr));
    chk({tag, " wr_adr_a"}, wa, e.wa);
    chk({tag, " wr_adr_b"}, wb, e.wb);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m3", model(3, 2, act3, t3), busy3, done3, int'(stage3), rd_en3,
          int'(ra3), int'(rb3), int'(tw3), wr_en3, int'(wa3), int'(wb3));
      cmp("m10", model(10, 4, act10, t10), busy10, done10, int'(stage10), rd_en10,
          int'(ra10), int'(rb10), int'(tw10), wr_en10, int'(wa10), int'(wb10));
    end
  end

  int lra[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lrb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int ltw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // Called at the negedge of cycle 0; checks literal reads/writes/done through cycle 19.
  task automatic basic3(input int extra);
    int rdi, wri;
    start3 = 1'b1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      @(negedge clk);
      start3 = (cyc == extra);
      rdi = -1;
      wri = -1;
      for (int i = 0; i < 12; i++) begin
        if (1 + (i / 4) * 6 + (i % 4) == cyc) rdi = i;
        if (3 + (i / 4) * 6 + (i % 4) == cyc) wri = i;
      end
      chk("lit rd_en", int'(rd_en3), int'(rdi >= 0));
      if (rdi >= 0) begin
        chk("lit rd_adr_a", int'(ra3), lra[rdi]);
        chk("lit rd_adr_b", int'(rb3), lrb[rdi]);
        chk("lit tw_adr", int'(tw3), ltw[rdi]);
      end
      chk("lit wr_en", int'(wr_en3), int'(wri >= 0));
      if (wri >= 0) begin
        chk("lit wr_adr_a", int'(wa3), lra[wri]);
        chk("lit wr_adr_b", int'(wb3), lrb[wri]);
      end
      chk("lit done", int'(done3), int'(cyc == 19));
    end
  endtask

  initial begin
    fft_pkg::bf_t bf;
    exp_t e;
    int   seen;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset busy", int'(busy3), 0);
    chk("reset rd_en", int'(rd_en3), 0);
    chk("reset wr_en", int'(wr_en3), 0);
    chk("reset done", int'(done10), 0);
    rst3  = 1'b0;
    rst10 = 1'b0;
    @(negedge clk);

    bf = fft_pkg::bf_addr(4'd3, 4'd1, 12'd1);
    chk("bf_addr 3/1/1 a", int'(bf.adr_a), 1);
    chk("bf_addr 3/1/1 b", int'(bf.adr_b), 3);
    chk("bf_addr 3/1/1 tw", int'(bf.tw), 2);
    bf = fft_pkg::bf_addr(4'd10, 4'd9, 12'd511);
    chk("bf_addr 10/9/511 b", int'(bf.adr_b), 1023);
    chk("bf_addr 10/9/511 tw", int'(bf.tw), 511);
    e = model(3, 2, 1'b1, 8);
    chk("model c8 a", e.ra, 1);
    chk("model c8 tw", e.tw, 2);

    // Basic transform
    basic3(-1);
    @(negedge clk);
    chk("idle after done", int'(busy3), 0);

    // Start pulsed while busy is ignored; start held across done restarts right after
    basic3(5);
    start3 = 1'b1;
    @(negedge clk);
    chk("b2b no rd in idle", int'(rd_en3), 0);
    @(negedge clk);
    start3 = 1'b0;
    chk("b2b rd_en", int'(rd_en3), 1);
    chk("b2b rd_adr_b", int'(rb3), 1);
    seen = -1;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done3) begin seen = cyc; break; end
    end
    chk("b2b done cycle", seen, 19);

    // ce stall mid-stage-1
    @(negedge clk);
    start3 = 1'b1;
    seen = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (cyc == 8) ce3 = 1'b0;
      if (cyc == 13) ce3 = 1'b1;
      if (cyc == 11) begin
        chk("stall hold a", int'(ra3), 1);
        chk("stall hold b", int'(rb3), 3);
      end
      if (cyc == 14) chk("stall resume a", int'(ra3), 4);
      if (done3) begin seen = cyc; break; end
    end
    chk("stall done cycle", seen, 24);

    // Reset during stage 1
    @(negedge clk);
    start3 = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      start3 = 1'b0;
    end
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("rst busy", int'(busy3), 0);
    chk("rst rd_en", int'(rd_en3), 0);
    chk("rst stage", int'(stage3), 0);
    chk("rst rd_adr_b", int'(rb3), 0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      chk("rst no wr_en", int'(wr_en3), 0);
    end
    basic3(-1);

    // Large configuration
    @(negedge clk);
    start10 = 1'b1;
    seen = -1;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      @(negedge clk);
      start10 = 1'b0;
      if (done10) begin seen = cyc; break; end
    end
    chk("large done cycle", seen, TD10);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
